// File: rtl/game_sprite_control.sv
// game_sprite_control: per-sprite position/velocity unit for the game datapath.
// Holds sprite position and velocity, advances position on step ticks and
// reports whether the sprite is fully inside the visible screen area.
//
// Build option: define GAME_SPRITE_STROBE_EN to pace motion with a step counter
// (one step every STROBE_PERIOD enabled cycles). When it is left undefined the
// counter is not built and the sprite steps on every enabled cycle, which keeps
// simulations short.
module game_sprite_control #(
  parameter int X_WIDTH       = 10,
  parameter int Y_WIDTH       = 10,
  parameter int DXY_WIDTH     = 3,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int SPRITE_WIDTH  = 8,
  parameter int SPRITE_HEIGHT = 8,
  parameter int STROBE_PERIOD = 2**20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sprite_write_xy,
  input  logic                 sprite_write_dxy,
  input  logic [X_WIDTH-1:0]   sprite_write_x,
  input  logic [Y_WIDTH-1:0]   sprite_write_y,
  input  logic [DXY_WIDTH-1:0] sprite_write_dx,
  input  logic [DXY_WIDTH-1:0] sprite_write_dy,
  input  logic                 sprite_enable_update,
  output logic [X_WIDTH-1:0]   sprite_x,
  output logic [Y_WIDTH-1:0]   sprite_y,
  output logic                 sprite_within_screen
);

  // Screen limits widened by one bit so the edge sums cannot overflow.
  localparam logic [X_WIDTH:0] SCREEN_W_EXT = (X_WIDTH+1)'(SCREEN_WIDTH);
  localparam logic [Y_WIDTH:0] SCREEN_H_EXT = (Y_WIDTH+1)'(SCREEN_HEIGHT);
  localparam logic [X_WIDTH:0] SPRITE_W_EXT = (X_WIDTH+1)'(SPRITE_WIDTH);
  localparam logic [Y_WIDTH:0] SPRITE_H_EXT = (Y_WIDTH+1)'(SPRITE_HEIGHT);

  // Motion needs at least two cycles per step to be meaningful.
  if (STROBE_PERIOD < 2) begin : g_bad_strobe_period
    $error("game_sprite_control: STROBE_PERIOD must be at least 2");
  end

  logic [X_WIDTH-1:0]   x_q,  x_d;
  logic [Y_WIDTH-1:0]   y_q,  y_d;
  logic [DXY_WIDTH-1:0] dx_q, dx_d;
  logic [DXY_WIDTH-1:0] dy_q, dy_d;
  logic                 tick_s;
  logic [X_WIDTH-1:0]   dx_ext_s;
  logic [Y_WIDTH-1:0]   dy_ext_s;
  logic [X_WIDTH:0]     x_right_s;
  logic [Y_WIDTH:0]     y_bottom_s;

`ifdef GAME_SPRITE_STROBE_EN
  localparam int CNT_W = (STROBE_PERIOD > 2) ? $clog2(STROBE_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STROBE_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Step counter: runs while enabled, restarts on a position load or when
  // motion is disabled so partial counts are discarded.
  always_comb begin
    cnt_d = cnt_q;
    if (!sprite_enable_update || sprite_write_xy) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Step tick fires on the last count of each period while enabled.
  always_comb begin
    tick_s = sprite_enable_update & (cnt_q == CNT_MAX);
  end

  // Step counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // Without pacing the sprite steps on every enabled cycle.
  always_comb begin
    tick_s = sprite_enable_update;
  end
`endif

  // Sign-extend velocity to the position widths; the add then wraps modulo
  // 2^width, so a negative step from 0 lands at the top of the range.
  always_comb begin
    dx_ext_s = {{(X_WIDTH-DXY_WIDTH){dx_q[DXY_WIDTH-1]}}, dx_q};
    dy_ext_s = {{(Y_WIDTH-DXY_WIDTH){dy_q[DXY_WIDTH-1]}}, dy_q};
  end

  // Next position: a load wins over a step; otherwise hold.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (sprite_write_xy) begin
      x_d = sprite_write_x;
      y_d = sprite_write_y;
    end else if (tick_s) begin
      x_d = x_q + dx_ext_s;
      y_d = y_q + dy_ext_s;
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
  end

  // Next velocity: a step in the same cycle as a velocity load still uses the
  // old velocity because the step reads dx_q/dy_q, not the load value.
  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    if (sprite_write_dxy) begin
      dx_d = sprite_write_dx;
      dy_d = sprite_write_dy;
    end else begin
      dx_d = dx_q;
      dy_d = dy_q;
    end
  end

  // Position and velocity registers; reset overrides any load or step.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q  <= '0;
      y_q  <= '0;
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  // On-screen test from the registered position; a wrapped negative position
  // is a large unsigned value and therefore reads as off-screen.
  always_comb begin
    x_right_s  = {1'b0, x_q} + SPRITE_W_EXT;
    y_bottom_s = {1'b0, y_q} + SPRITE_H_EXT;
    sprite_within_screen = (x_right_s <= SCREEN_W_EXT) & (y_bottom_s <= SCREEN_H_EXT);
  end

  assign sprite_x = x_q;
  assign sprite_y = y_q;

endmodule

// File: tb/tb_game_sprite_control.sv
// Self-checking bench for game_sprite_control with STROBE_PERIOD=4.
// A behavioural model (integer arithmetic) predicts position and the on-screen
// flag every cycle; directed scenarios are followed by randomized traffic.
module tb_game_sprite_control;

  localparam int SP = 4;
`ifdef GAME_SPRITE_STROBE_EN
  localparam int MP = SP;
`else
  localparam int MP = 1;
`endif

  logic       clk;
  logic       reset;
  logic       sprite_write_xy;
  logic       sprite_write_dxy;
  logic [9:0] sprite_write_x;
  logic [9:0] sprite_write_y;
  logic [2:0] sprite_write_dx;
  logic [2:0] sprite_write_dy;
  logic       sprite_enable_update;
  logic [9:0] sprite_x;
  logic [9:0] sprite_y;
  logic       sprite_within_screen;

  int checks = 0;
  int errors = 0;

  // model state
  int mx = 0, my = 0, mdx = 0, mdy = 0, mcnt = 0;

  game_sprite_control #(.STROBE_PERIOD(SP)) dut (
    .clk(clk),
    .reset(reset),
    .sprite_write_xy(sprite_write_xy),
    .sprite_write_dxy(sprite_write_dxy),
    .sprite_write_x(sprite_write_x),
    .sprite_write_y(sprite_write_y),
    .sprite_write_dx(sprite_write_dx),
    .sprite_write_dy(sprite_write_dy),
    .sprite_enable_update(sprite_enable_update),
    .sprite_x(sprite_x),
    .sprite_y(sprite_y),
    .sprite_within_screen(sprite_within_screen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wrap1024(input int v);
    return ((v % 1024) + 1024) % 1024;
  endfunction

  // One clock cycle: drive inputs, advance the model at the edge, then compare.
  task automatic cyc(input logic rst, input logic en, input logic wxy, input logic wdxy,
                     input int wx, input int wy, input logic [2:0] wdx, input logic [2:0] wdy);
    logic tick;
    logic [9:0] ex, ey;
    logic ew;
    reset = rst;
    sprite_enable_update = en;
    sprite_write_xy = wxy;
    sprite_write_dxy = wdxy;
    sprite_write_x = 10'(wx);
    sprite_write_y = 10'(wy);
    sprite_write_dx = wdx;
    sprite_write_dy = wdy;
    @(posedge clk);
    if (rst) begin
      mx = 0; my = 0; mdx = 0; mdy = 0; mcnt = 0;
    end else begin
      tick = en && (mcnt == MP - 1);
      if (wxy) begin
        mx = wx; my = wy;
      end else if (tick) begin
        mx = wrap1024(mx + mdx);
        my = wrap1024(my + mdy);
      end
      if (wdxy) begin
        mdx = int'($signed(wdx));
        mdy = int'($signed(wdy));
      end
      mcnt = (!en || wxy) ? 0 : (mcnt + 1) % MP;
    end
    #1;
    ex = 10'(mx);
    ey = 10'(my);
    ew = (mx + 8 <= 640) && (my + 8 <= 480);
    checks++;
    assert (sprite_x === ex) else begin
      errors++;
      $error("FAIL sprite_x: got %0d expected %0d at %0t", sprite_x, ex, $time);
    end
    checks++;
    assert (sprite_y === ey) else begin
      errors++;
      $error("FAIL sprite_y: got %0d expected %0d at %0t", sprite_y, ey, $time);
    end
    checks++;
    assert (sprite_within_screen === ew) else begin
      errors++;
      $error("FAIL within: got %0b expected %0b (x=%0d y=%0d) at %0t",
             sprite_within_screen, ew, mx, my, $time);
    end
  endtask

  task automatic idle(input int n, input logic en);
    for (int i = 0; i < n; i++) cyc(1'b0, en, 1'b0, 1'b0, 0, 0, 3'd0, 3'd0);
  endtask

  initial begin
    reset = 1'b1;
    sprite_enable_update = 1'b0;
    sprite_write_xy = 1'b0;
    sprite_write_dxy = 1'b0;
    sprite_write_x = 10'd0;
    sprite_write_y = 10'd0;
    sprite_write_dx = 3'd0;
    sprite_write_dy = 3'd0;

    // reset for two cycles, then nothing moves with enable low
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 3'd0, 3'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 3'd0, 3'd0);
    idle(3, 1'b0);

    // load (100,200), velocity (+2,-1), enable 12 cycles
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 100, 200, 3'd2, 3'b111);
    idle(12, 1'b1);
    idle(2, 1'b0);

    // wrap through zero to 1023 (off-screen)
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1, 0, 3'b111, 3'd0);
    idle(3 * MP, 1'b1);
    idle(1, 1'b0);

    // right and bottom screen boundaries
    for (int v = 629; v <= 634; v++) cyc(1'b0, 1'b0, 1'b1, 1'b0, v, 100, 3'd0, 3'd0);
    for (int v = 470; v <= 475; v++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 100, v, 3'd0, 3'd0);

    // position load on a tick cycle wins and restarts the count
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 50, 60, 3'd1, 3'd1);
    idle(MP - 1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 300, 300, 3'd0, 3'd0);
    idle(2 * MP, 1'b1);

    // velocity load on a tick cycle: that step uses the old velocity
    idle(MP - 1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 3'b101, 3'd3);
    idle(2 * MP, 1'b1);

    // reset mid-motion with a concurrent position load, then re-enable
    idle(2, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 400, 400, 3'd3, 3'd3);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 200, 150, 3'd0, 3'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 3'd1, 3'd2);
    idle(2 * MP + 1, 1'b1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 14) == 0),
          int'($urandom_range(0, 1023)),
          int'($urandom_range(0, 1023)),
          3'($urandom_range(0, 7)),
          3'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
